// File: rtl/cavlc_bitstream_writer.sv
// CAVLC bitstream writer: packs raw VLC codes and H.264 level codes
// MSB-first into 16-bit words, with flush/zero-pad support.
// Ports: Clk/Reset (sync, active-high); SymValid/SymReady/SymKind/SymCode/
//   SymLen/LevelStart/LevelSuffixInit/LevelAdj symbol input;
//   BitstreamData/WrReq/Full sink side; FlushDone flush-complete pulse.
// Optional: define CAVLC_BITCOUNT_EN to add the BitCount output.
module cavlc_bitstream_writer #(
    parameter int ACC_W     = 48,
    parameter int LEVEL_MAX = 2047
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        SymValid,
    output logic        SymReady,
    input  logic [1:0]  SymKind,
    input  logic [15:0] SymCode,
    input  logic [4:0]  SymLen,
    input  logic        LevelStart,
    input  logic        LevelSuffixInit,
    input  logic        LevelAdj,
    output logic [15:0] BitstreamData,
    output logic        WrReq,
    input  logic        Full,
`ifdef CAVLC_BITCOUNT_EN
    output logic [15:0] BitCount,
`endif
    output logic        FlushDone
);

    localparam int CW = $clog2(ACC_W + 1);
    localparam logic [CW-1:0] WORD = CW'(16);

    typedef enum logic [1:0] {S_RUN, S_PAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        sl_q, sl_d;
    logic [15:0]       data_q, data_d;
    logic              wr_q, wr_d;
    logic              fd_q, fd_d;

    // Level encoder signals
    logic [12:0] lvl_abs;
    logic [11:0] mag;
    logic        lvl_zero;
    logic [12:0] lc;
    logic [2:0]  sl_eff, sl_n;
    logic [12:0] thr;
    logic [3:0]  plen, slen;
    logic [11:0] suf;
    logic [4:0]  lev_len;
    logic [27:0] lev_bits;

    // Raw path
    logic [4:0]  raw_len;
    logic [16:0] raw_mask;

    logic        fire;
    logic [4:0]  app_len;
    logic [27:0] app_bits;
    logic [CW-1:0] shamt;

    assign SymReady = (state_q == S_RUN) && (cnt_q < WORD) && !Reset;
    assign fire     = SymValid && SymReady;

    assign BitstreamData = data_q;
    assign WrReq         = wr_q;
    assign FlushDone     = fd_q;

    always_comb begin
        lvl_abs  = SymCode[12] ? (~SymCode[12:0] + 13'd1) : SymCode[12:0];
        mag      = (lvl_abs > 13'(LEVEL_MAX)) ? 12'(LEVEL_MAX) : lvl_abs[11:0];
        lvl_zero = (lvl_abs == 13'd0);
        lc       = SymCode[12] ? ({mag, 1'b0} - 13'd1) : ({mag, 1'b0} - 13'd2);
        if (LevelStart && LevelAdj) lc = lc - 13'd2;
        sl_eff   = LevelStart ? {2'b00, LevelSuffixInit} : sl_q;
        thr      = 13'd15 << sl_eff;
        // Escape (prefix 15, 12-bit suffix) is the default
        plen     = 4'd15;
        slen     = 4'd12;
        suf      = 12'd0;
        if (sl_eff == 3'd0) begin
            if (lc < 13'd14) begin
                plen = lc[3:0];
                slen = 4'd0;
            end else if (lc < 13'd30) begin
                plen = 4'd14;
                slen = 4'd4;
                suf  = 12'(lc - 13'd14);
            end else begin
                suf  = 12'(lc - 13'd30);
            end
        end else if (lc < thr) begin
            plen = 4'(lc >> sl_eff);
            slen = {1'b0, sl_eff};
            suf  = 12'(lc & ((13'd1 << sl_eff) - 13'd1));
        end else begin
            suf  = 12'(lc - thr);
        end
        lev_len  = 5'(plen) + 5'd1 + 5'(slen);
        // Leading zeros are implicit: only the marker 1 and suffix are set
        lev_bits = (28'd1 << slen) | 28'(suf);
        sl_n     = (sl_eff == 3'd0) ? 3'd1 : sl_eff;
        if (sl_n < 3'd6 && {1'b0, mag} > (13'd3 << (sl_n - 3'd1)))
            sl_n = sl_n + 3'd1;
    end

    always_comb begin
        raw_len  = (SymLen > 5'd16) ? 5'd16 : SymLen;
        raw_mask = (17'd1 << raw_len) - 17'd1;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sl_d     = sl_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        fd_d     = 1'b0;
        app_len  = 5'd0;
        app_bits = 28'd0;
        unique case (state_q)
            S_RUN: begin
                if (cnt_q >= WORD) begin
                    if (!Full) begin
                        data_d = acc_q[ACC_W-1 -: 16];
                        wr_d   = 1'b1;
                        acc_d  = acc_q << 16;
                        cnt_d  = cnt_q - WORD;
                    end
                end else if (fire) begin
                    case (SymKind)
                        2'b00: begin
                            app_len  = raw_len;
                            app_bits = {12'd0, SymCode & raw_mask[15:0]};
                        end
                        2'b01: begin
                            if (!lvl_zero) begin
                                app_len  = lev_len;
                                app_bits = lev_bits;
                                sl_d     = sl_n;
                            end
                        end
                        2'b10: state_d = (cnt_q == '0) ? S_DONE : S_PAD;
                        default: ;
                    endcase
                end
            end
            S_PAD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else if (!Full) begin
                    // Bits below cnt are always zero, so the pad is free
                    data_d  = acc_q[ACC_W-1 -: 16];
                    wr_d    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                fd_d    = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        shamt = CW'(ACC_W) - cnt_q - CW'(app_len);
        if (app_len != 5'd0) begin
            acc_d = acc_q | ({{(ACC_W-28){1'b0}}, app_bits} << shamt);
            cnt_d = cnt_q + CW'(app_len);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            sl_q    <= 3'd0;
            data_q  <= 16'd0;
            wr_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            fd_q    <= fd_d;
        end
    end

`ifdef CAVLC_BITCOUNT_EN
    logic [15:0] bc_q, bc_d;
    logic [15:0] bc_base;
    logic [16:0] bc_sum;

    always_comb begin
        // The cycle showing FlushDone is the last one the old count is visible
        bc_base = fd_q ? 16'd0 : bc_q;
        bc_sum  = {1'b0, bc_base} + 17'(app_len);
        bc_d    = bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) bc_q <= 16'd0;
        else       bc_q <= bc_d;
    end

    assign BitCount = bc_q;
`endif

endmodule

// File: tb/tb_cavlc_bitstream_writer.sv
// Directed testbench for cavlc_bitstream_writer.
// Scenario tasks with inline checks; one summary line at the end.
module tb_cavlc_bitstream_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        SymValid;
    logic        SymReady;
    logic [1:0]  SymKind;
    logic [15:0] SymCode;
    logic [4:0]  SymLen;
    logic        LevelStart;
    logic        LevelSuffixInit;
    logic        LevelAdj;
    logic [15:0] BitstreamData;
    logic        WrReq;
    logic        Full;
    logic        FlushDone;
`ifdef CAVLC_BITCOUNT_EN
    logic [15:0] BitCount;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] words[$];
    int cyc = 0;
    int wr_cyc = 0;
    int fd_cyc = 0;
    int fd_cnt = 0;
    int wr_full_viol = 0;
    logic full_s = 1'b0;

    always #5 Clk = ~Clk;

    cavlc_bitstream_writer dut (
        .Clk(Clk),
        .Reset(Reset),
        .SymValid(SymValid),
        .SymReady(SymReady),
        .SymKind(SymKind),
        .SymCode(SymCode),
        .SymLen(SymLen),
        .LevelStart(LevelStart),
        .LevelSuffixInit(LevelSuffixInit),
        .LevelAdj(LevelAdj),
        .BitstreamData(BitstreamData),
        .WrReq(WrReq),
        .Full(Full),
`ifdef CAVLC_BITCOUNT_EN
        .BitCount(BitCount),
`endif
        .FlushDone(FlushDone)
    );

    always @(posedge Clk) begin
        cyc    <= cyc + 1;
        full_s <= Full;
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            if (WrReq) begin
                words.push_back(BitstreamData);
                wr_cyc <= cyc;
                if (full_s) wr_full_viol <= wr_full_viol + 1;
            end
            if (FlushDone) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset    = 1'b1;
        SymValid = 1'b0;
        Full     = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        words.delete();
    endtask

    task automatic send(input logic [1:0] k, input logic [15:0] code,
                        input logic [4:0] len, input logic st,
                        input logic init, input logic adj);
        bit ok;
        @(negedge Clk);
        SymKind         = k;
        SymCode         = code;
        SymLen          = len;
        LevelStart      = st;
        LevelSuffixInit = init;
        LevelAdj        = adj;
        SymValid        = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (SymReady) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (ok) begin
            @(posedge Clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: SymReady=%b required 1", SymReady);
        end
        SymValid = 1'b0;
    endtask

    task automatic raw(input logic [15:0] code, input logic [4:0] len);
        send(2'b00, code, len, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic level(input logic [12:0] l, input logic st,
                         input logic init, input logic adj);
        send(2'b01, {3'b000, l}, 5'd0, st, init, adj);
    endtask

    task automatic wait_flush(output bit ok);
        int s;
        send(2'b10, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        s  = fd_cnt;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge Clk);
            if (fd_cnt != s) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (SymReady !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b required 0", SymReady);
        end
        checks++;
        if (WrReq !== 1'b0) begin
            errors++;
            $display("FAIL rst_wrreq: got %b required 0", WrReq);
        end
        checks++;
        if (FlushDone !== 1'b0) begin
            errors++;
            $display("FAIL rst_flushdone: got %b required 0", FlushDone);
        end
        checks++;
        if (BitstreamData !== 16'h0000) begin
            errors++;
            $display("FAIL rst_data: got %h required 0000", BitstreamData);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (SymReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_after: got %b required 1", SymReady);
        end
        words.delete();
    endtask

    task automatic test_raw_flush();
        bit ok;
        do_reset();
        raw(16'h0005, 5'd3);
        wait_flush(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL raw_flush_done: FlushDone not seen, required pulse");
        end
        checks++;
        if (words.size() != 1 || words[0] !== 16'hA000) begin
            errors++;
            $display("FAIL raw_flush_word: got n=%0d w0=%h required n=1 A000",
                     words.size(), words[0]);
        end
        checks++;
        if (fd_cyc != wr_cyc + 1) begin
            errors++;
            $display("FAIL raw_flush_timing: FlushDone cycle %0d required %0d",
                     fd_cyc, wr_cyc + 1);
        end
    endtask

    task automatic test_level_pm1();
        bit ok;
        do_reset();
        level(13'd1, 1'b1, 1'b0, 1'b0);
        level(13'h1FFF, 1'b0, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 1 || words[0] !== 16'hE000) begin
            errors++;
            $display("FAIL level_pm1: ok=%b n=%0d w0=%h required 1 1 E000",
                     ok, words.size(), words[0]);
        end
        // suffixLength stays 1 across FLUSH: +2 codes as 010
        words.delete();
        level(13'd2, 1'b0, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 1 || words[0] !== 16'h4000) begin
            errors++;
            $display("FAIL level_sl1_kept: ok=%b n=%0d w0=%h required 1 1 4000",
                     ok, words.size(), words[0]);
        end
    endtask

    task automatic test_level_adapt();
        bit ok;
        do_reset();
        level(13'd5, 1'b1, 1'b0, 1'b0);
        level(13'd4, 1'b0, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 1 || words[0] !== 16'h00B0) begin
            errors++;
            $display("FAIL level_adapt: ok=%b n=%0d w0=%h required 1 1 00B0",
                     ok, words.size(), words[0]);
        end
        // Adj with Init1: +3 -> 010 (sl 1), then -4 -> 00011
        words.delete();
        level(13'd3, 1'b1, 1'b1, 1'b1);
        level(13'h1FFC, 1'b0, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 1 || words[0] !== 16'h4300) begin
            errors++;
            $display("FAIL level_adj: ok=%b n=%0d w0=%h required 1 1 4300",
                     ok, words.size(), words[0]);
        end
    endtask

    task automatic test_level_escape();
        bit ok;
        do_reset();
        level(13'h1801, 1'b1, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 2) begin
            errors++;
            $display("FAIL esc_neg_count: ok=%b n=%0d required 1 2", ok, words.size());
        end
        checks++;
        if (words[0] !== 16'h0001 || words[1] !== 16'hFDF0) begin
            errors++;
            $display("FAIL esc_neg_words: got %h %h required 0001 FDF0",
                     words[0], words[1]);
        end
        words.delete();
        level(13'd3000, 1'b1, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 2) begin
            errors++;
            $display("FAIL esc_clamp_count: ok=%b n=%0d required 1 2", ok, words.size());
        end
        checks++;
        if (words[0] !== 16'h0001 || words[1] !== 16'hFDE0) begin
            errors++;
            $display("FAIL esc_clamp_words: got %h %h required 0001 FDE0",
                     words[0], words[1]);
        end
    endtask

    task automatic test_edge_cases();
        bit ok;
        do_reset();
        raw(16'hFFFF, 5'd0);
        level(13'd0, 1'b1, 1'b1, 1'b0);
        send(2'b11, 16'hFFFF, 5'd16, 1'b0, 1'b0, 1'b0);
        raw(16'hFFFD, 5'd3);
        raw(16'hFFFF, 5'd20);
        level(13'd1, 1'b0, 1'b0, 1'b0);
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 2) begin
            errors++;
            $display("FAIL edge_count: ok=%b n=%0d required 1 2", ok, words.size());
        end
        checks++;
        if (words[0] !== 16'hBFFF || words[1] !== 16'hF000) begin
            errors++;
            $display("FAIL edge_words: got %h %h required BFFF F000",
                     words[0], words[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad;
        do_reset();
        Full = 1'b1;
        raw(16'h1234, 5'd16);
        bad = 0;
        fork
            begin
                raw(16'h5678, 5'd16);
                raw(16'h9ABC, 5'd16);
                raw(16'hDEF0, 5'd16);
            end
            begin
                repeat (10) begin
                    @(negedge Clk);
                    if (WrReq || SymReady) bad++;
                end
                Full = 1'b0;
            end
        join
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_hold: %0d cycles with WrReq/SymReady high, required 0", bad);
        end
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: ok=%b n=%0d required 1 4", ok, words.size());
        end
        checks++;
        if (words[0] !== 16'h1234 || words[1] !== 16'h5678 ||
            words[2] !== 16'h9ABC || words[3] !== 16'hDEF0) begin
            errors++;
            $display("FAIL b2b_order: got %h %h %h %h required 1234 5678 9ABC DEF0",
                     words[0], words[1], words[2], words[3]);
        end
        checks++;
        if (wr_full_viol != 0) begin
            errors++;
            $display("FAIL b2b_full_wr: %0d writes while Full, required 0", wr_full_viol);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        raw(16'h007F, 5'd7);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (WrReq !== 1'b0 || FlushDone !== 1'b0 || BitstreamData !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: wr=%b fd=%b data=%h required 0 0 0000",
                     WrReq, FlushDone, BitstreamData);
        end
        Reset = 1'b0;
        words.delete();
        wait_flush(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_flushdone: FlushDone not seen, required pulse");
        end
        checks++;
        if (words.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_nowrite: got %0d words required 0", words.size());
        end
    endtask

`ifdef CAVLC_BITCOUNT_EN
    task automatic test_bitcount();
        bit ok;
        do_reset();
        raw(16'h0000, 5'd5);
        level(13'd1, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        checks++;
        if (BitCount !== 16'd6) begin
            errors++;
            $display("FAIL bitcount_val: got %0d required 6", BitCount);
        end
        wait_flush(ok);
        checks++;
        if (!ok || words.size() != 1 || words[0] !== 16'h0400) begin
            errors++;
            $display("FAIL bitcount_word: ok=%b n=%0d w0=%h required 1 1 0400",
                     ok, words.size(), words[0]);
        end
        @(negedge Clk);
        checks++;
        if (BitCount !== 16'd0) begin
            errors++;
            $display("FAIL bitcount_clear: got %0d required 0", BitCount);
        end
    endtask
`endif

    initial begin
        Reset           = 1'b1;
        SymValid        = 1'b0;
        SymKind         = 2'b00;
        SymCode         = 16'h0;
        SymLen          = 5'd0;
        LevelStart      = 1'b0;
        LevelSuffixInit = 1'b0;
        LevelAdj        = 1'b0;
        Full            = 1'b0;
        test_reset();
        test_raw_flush();
        test_level_pm1();
        test_level_adapt();
        test_level_escape();
        test_edge_cases();
        test_back_to_back();
        test_reset_mid();
`ifdef CAVLC_BITCOUNT_EN
        test_bitcount();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
